// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - two-producer FIFO write arbiter with read issue and occupancy tracking
// Defining FIFO_ARB_STATS_EN adds saturating per-producer grant counters gnt_cnt0/gnt_cnt1.

module fifo_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DATA_W-1:0] fifo_data_in,
    output logic              fifo_en_write,
    output logic              fifo_en_read,
    input  logic              fifo_overflow,
    input  logic              fifo_underflow,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              err
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1
`endif
);

    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_wr;
    logic              r_rd;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic              r_last;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_issue;
    logic              w_wr_issue;
    logic              w_win1;
    logic [CNT_W-1:0]  w_count_nxt;

    assign w_full     = (r_count == L_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_rd_issue = rd_req && !w_empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_wr_issue = (req0 || req1) && (!w_full || w_rd_issue);
    // On conflict the producer that did not win last time gets the slot.
    assign w_win1     = req1 && (!req0 || !r_last);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_issue && !w_rd_issue) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_rd_issue && !w_wr_issue) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_gnt0  <= w_wr_issue && !w_win1;
            r_gnt1  <= w_wr_issue && w_win1;
            r_wr    <= w_wr_issue;
            r_rd    <= w_rd_issue;
            r_count <= w_count_nxt;
            if (w_wr_issue) begin
                r_data <= w_win1 ? data1 : data0;
                r_last <= w_win1;
            end
            if (fifo_overflow || fifo_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign gnt0          = r_gnt0;
    assign gnt1          = r_gnt1;
    assign fifo_en_write = r_wr;
    assign fifo_en_read  = r_rd;
    assign rd_ack        = r_rd;
    assign fifo_data_in  = r_data;
    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;
    assign err           = r_err;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_gnt_cnt0;
    logic [15:0] r_gnt_cnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else begin
            if (w_wr_issue && !w_win1 && r_gnt_cnt0 != 16'hFFFF) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
            end
            if (w_wr_issue && w_win1 && r_gnt_cnt1 != 16'hFFFF) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
            end
        end
    end

    assign gnt_cnt0 = r_gnt_cnt0;
    assign gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter (vector table, corner sequences, random vs queue model)

module tb_fifo_write_arbiter;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset, req0, req1, rd_req, fifo_overflow, fifo_underflow;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, rd_ack, fifo_en_write, fifo_en_read, full, empty, err;
    logic [7:0] fifo_data_in;
    logic [4:0] count;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    fifo_write_arbiter dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .rd_req(rd_req), .rd_ack(rd_ack), .fifo_data_in(fifo_data_in),
        .fifo_en_write(fifo_en_write), .fifo_en_read(fifo_en_read),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
        .count(count), .full(full), .empty(empty), .err(err)
`ifdef FIFO_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    typedef struct {
        logic [3:0] ctl;   // {reset, req0, req1, rd_req}
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ovf;
        logic [3:0] st;    // expected {gnt0, gnt1, fifo_en_write, fifo_en_read}
        logic [7:0] dat;
        logic [4:0] cnt;
        logic       er;
    } vec_t;

    vec_t tbl[16];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: the FIFO contents as a queue; occupancy is simply its size.
    logic [7:0] mq[$];
    int         last_m;
    logic       err_m;
    logic [7:0] data_m;
    logic [3:0] e_st;

    function automatic vec_t mk(logic [3:0] ctl, logic [7:0] d0, logic [7:0] d1, logic ovf,
                                logic [3:0] st, logic [7:0] dat, logic [4:0] cnt, logic er);
        vec_t v;
        v.ctl = ctl; v.d0 = d0; v.d1 = d1; v.ovf = ovf;
        v.st = st; v.dat = dat; v.cnt = cnt; v.er = er;
        return v;
    endfunction

    function automatic logic [31:0] dut_pack();
        return {11'd0, gnt0, gnt1, fifo_en_write, fifo_en_read, rd_ack,
                fifo_data_in, count, full, empty, err};
    endfunction

    function automatic logic [31:0] exp_pack(logic [3:0] st, logic [7:0] dat, logic [4:0] cnt, logic er);
        return {11'd0, st, st[0], dat, cnt, cnt == 5'd16, cnt == 5'd0, er};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int  winner;
        bit  rd_ok;
        bit  wr_ok;
        if (reset) begin
            mq.delete();
            last_m = 1;
            err_m  = 1'b0;
            data_m = 8'h00;
            e_st   = 4'b0000;
        end else begin
            rd_ok = rd_req && (mq.size() > 0);
            if (req0 && req1) winner = 1 - last_m;
            else              winner = req1 ? 1 : 0;
            wr_ok = (req0 || req1) && (mq.size() < DEPTH || rd_ok);
            if (rd_ok) void'(mq.pop_front());
            if (wr_ok) begin
                data_m = (winner == 1) ? data1 : data0;
                mq.push_back(data_m);
                last_m = winner;
            end
            if (fifo_overflow || fifo_underflow) err_m = 1'b1;
            e_st = {wr_ok && winner == 0, wr_ok && winner == 1, wr_ok, rd_ok};
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        cmp(tag, dut_pack(), exp_pack(e_st, data_m, 5'(mq.size()), err_m));
    endtask

    task automatic set_in(input logic rst, input logic r0, input logic r1, input logic rd);
        reset = rst; req0 = r0; req1 = r1; rd_req = rd;
        fifo_overflow = 1'b0; fifo_underflow = 1'b0;
    endtask

    initial begin
        int n;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        data0 = 8'h00; data1 = 8'h00;

        tbl[0]  = mk(4'b1000, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00, 5'd0, 1'b0);
        tbl[1]  = mk(4'b0110, 8'hA0, 8'hB1, 1'b0, 4'b1010, 8'hA0, 5'd1, 1'b0);
        tbl[2]  = mk(4'b0110, 8'hA0, 8'hB1, 1'b0, 4'b0110, 8'hB1, 5'd2, 1'b0);
        tbl[3]  = mk(4'b0110, 8'hA0, 8'hB1, 1'b0, 4'b1010, 8'hA0, 5'd3, 1'b0);
        tbl[4]  = mk(4'b0110, 8'hA0, 8'hB1, 1'b0, 4'b0110, 8'hB1, 5'd4, 1'b0);
        tbl[5]  = mk(4'b0001, 8'h00, 8'h00, 1'b0, 4'b0001, 8'hB1, 5'd3, 1'b0);
        tbl[6]  = mk(4'b0011, 8'h00, 8'hC2, 1'b0, 4'b0111, 8'hC2, 5'd3, 1'b0);
        tbl[7]  = mk(4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 8'hC2, 5'd3, 1'b1);
        tbl[8]  = mk(4'b0000, 8'h00, 8'h00, 1'b0, 4'b0000, 8'hC2, 5'd3, 1'b1);
        tbl[9]  = mk(4'b1000, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00, 5'd0, 1'b0);
        tbl[10] = mk(4'b0001, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00, 5'd0, 1'b0);
        tbl[11] = mk(4'b0110, 8'h11, 8'h22, 1'b0, 4'b1010, 8'h11, 5'd1, 1'b0);
        tbl[12] = mk(4'b0001, 8'h00, 8'h00, 1'b0, 4'b0001, 8'h11, 5'd0, 1'b0);
        tbl[13] = mk(4'b0001, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h11, 5'd0, 1'b0);
        tbl[14] = mk(4'b0010, 8'h00, 8'h33, 1'b0, 4'b0110, 8'h33, 5'd1, 1'b0);
        tbl[15] = mk(4'b1100, 8'h44, 8'h00, 1'b0, 4'b0000, 8'h00, 5'd0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0]);
            data0 = tbl[i].d0; data1 = tbl[i].d1; fifo_overflow = tbl[i].ovf;
            tick($sformatf("tbl%0d_model", i));
            cmp($sformatf("tbl%0d", i), dut_pack(), exp_pack(tbl[i].st, tbl[i].dat, tbl[i].cnt, tbl[i].er));
        end

        // Continuous conflict from reset alternates starting with producer 0.
        set_in(1'b1, 1'b0, 1'b0, 1'b0); tick("alt_reset");
        set_in(1'b0, 1'b1, 1'b1, 1'b0); data0 = 8'hA0; data1 = 8'hB1;
        for (int i = 0; i < 8; i++) begin
            tick("alt_model");
            cmp($sformatf("alt%0d", i), {gnt0, gnt1, fifo_data_in},
                (i % 2 == 0) ? {2'b10, 8'hA0} : {2'b01, 8'hB1});
        end
`ifdef FIFO_ARB_STATS_EN
        cmp("gnt_cnt0", gnt_cnt0, 32'd4);
        cmp("gnt_cnt1", gnt_cnt1, 32'd4);
`endif

        // Fill to capacity with no reads.
        set_in(1'b1, 1'b0, 1'b0, 1'b0); tick("fill_reset");
        set_in(1'b0, 1'b1, 1'b0, 1'b0); data0 = 8'h5A;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick("fill_model");
            if (gnt0) n++;
        end
        cmp("fill_grants", n, 32'd16);
        cmp("fill_state", {full, count, fifo_en_write}, {1'b1, 5'd16, 1'b0});

        // Full: simultaneous read and write keeps occupancy.
        set_in(1'b0, 1'b0, 1'b1, 1'b1); data1 = 8'hC3;
        tick("full_rw_model");
        cmp("full_rw", {fifo_en_write, fifo_en_read, gnt1, count}, {3'b111, 5'd16});

        // Reset in the middle of a burst drops everything; producer 0 wins next conflict.
        set_in(1'b1, 1'b0, 1'b0, 1'b0); tick("burst_reset");
        set_in(1'b0, 1'b1, 1'b0, 1'b0); data0 = 8'h77;
        repeat (7) tick("burst_model");
        cmp("burst_cnt", count, 32'd7);
        set_in(1'b1, 1'b1, 1'b1, 1'b1); data1 = 8'h88;
        tick("mid_reset_model");
        cmp("mid_reset", {count, gnt0, gnt1, fifo_en_write, fifo_en_read, rd_ack}, 32'd0);
        set_in(1'b0, 1'b1, 1'b1, 1'b0);
        tick("post_reset_model");
        cmp("post_reset_conflict", {gnt0, gnt1}, 32'b10);

        // Sticky error flag.
        set_in(1'b0, 1'b0, 1'b0, 1'b0); fifo_overflow = 1'b1;
        tick("err_model");
        cmp("err_set", err, 32'd1);
        fifo_overflow = 1'b0;
        repeat (3) tick("err_hold_model");
        cmp("err_sticky", err, 32'd1);
        set_in(1'b1, 1'b0, 1'b0, 1'b0); tick("err_reset_model");
        cmp("err_clear", err, 32'd0);

        // Random traffic with read pressure varying by phase so full and empty are both reached.
        for (int i = 0; i < 3000; i++) begin
            int rd_pct;
            rd_pct = ((i / 200) % 3 == 0) ? 10 : (((i / 200) % 3 == 1) ? 50 : 90);
            reset          = ($urandom_range(63) == 0);
            req0           = $urandom_range(1);
            req1           = $urandom_range(1);
            data0          = 8'($urandom);
            data1          = 8'($urandom);
            rd_req         = ($urandom_range(99) < rd_pct);
            fifo_overflow  = ($urandom_range(99) == 0);
            fifo_underflow = ($urandom_range(99) == 0);
            tick($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of the FIFO data word.
REQ-002 Parameter DEPTH, default 16: FIFO capacity in entries; a power of two, at least 2.
REQ-003 Parameter CNT_W, default 5: occupancy counter width; must satisfy 2**CNT_W > DEPTH.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 req0 / req1  input  1 each: producer 0 / producer 1 write request.
REQ-007 data0 / data1  input  DATA_W each: producer 0 / producer 1 write data, valid while the matching req is high.
REQ-008 gnt0 / gnt1  output  1 each: registered one-cycle acknowledge; the producer's word was issued to the FIFO.
REQ-009 rd_req  input  1: consumer read request.
REQ-010 rd_ack  output  1: registered; fifo_en_read was issued this cycle.
REQ-011 fifo_data_in  output  DATA_W: registered data to the FIFO data_in.
REQ-012 fifo_en_write / fifo_en_read  output  1 each: registered FIFO write / read strobes.
REQ-013 fifo_overflow / fifo_underflow  input  1 each: FIFO error flags.
REQ-014 count  output  CNT_W: tracked FIFO occupancy.
REQ-015 full / empty  output  1 each: count == DEPTH / count == 0.
REQ-016 err  output  1: sticky; set when fifo_overflow or fifo_underflow is sampled high.

Function
REQ-017 Arbitration SHALL sample req0, req1, rd_req, count and the priority pointer at edge N; the resulting strobes, grants, rd_ack and fifo_data_in SHALL be valid for the cycle after edge N (one-cycle latency).
REQ-018 Write eligibility: a write is eligible when full == 0, or when full == 1 and a read is issued in the same cycle.
REQ-019 Winner selection: with one requester, that requester wins; with both, the requester other than the priority pointer `last` wins.
REQ-020 On a write win, gnt<i>, fifo_en_write and fifo_data_in = data<i> SHALL all be registered, and `last` SHALL be set to i.
REQ-021 Exactly one of gnt0/gnt1 SHALL be high per cycle at most; a losing or blocked producer holds req and data until granted.
REQ-022 A read SHALL be issued (fifo_en_read = 1, rd_ack = 1) when rd_req == 1 and empty == 0; rd_req while empty SHALL be ignored.
REQ-023 Count update: +1 on write-only, -1 on read-only, unchanged on simultaneous read and write or on no operation; count SHALL never exceed DEPTH or go below 0.
REQ-024 A write and a read SHALL be issued in the same cycle whenever both are eligible.
REQ-025 fifo_data_in SHALL hold its last value when no write is issued.
REQ-026 err SHALL stay set until reset; it does not block operation.

Reset
REQ-027 While reset is high at an edge: gnt0 = gnt1 = rd_ack = fifo_en_write = fifo_en_read = 0, fifo_data_in = 0, count = 0, err = 0, last = 1 (req0 wins the first conflict).
REQ-028 Reset SHALL override any request in the same cycle; requests pending when reset is applied mid-operation are dropped, not queued.

Configuration
REQ-029 Macro FIFO_ARB_STATS_EN defined: add outputs gnt_cnt0 and gnt_cnt1 (16 bits each), each incremented on its grant, saturating at 16'hFFFF and cleared by reset.
REQ-030 Macro FIFO_ARB_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

Verification
REQ-031 Both producers request continuously (data0 = 8'hA0, data1 = 8'hB1) from reset: grants alternate gnt0, gnt1, gnt0, ... one per cycle; fifo_data_in alternates A0, B1.
REQ-032 req0 is held for 20 cycles with DEPTH = 16 and no reads: exactly 16 grants, then full = 1, count = 16, fifo_en_write stays 0; no overflow.
REQ-033 In the full state, req1 = 1 and rd_req = 1 in the same cycle: fifo_en_write = fifo_en_read = 1 in the same cycle; count stays 16.
REQ-034 rd_req = 1 while empty: fifo_en_read and rd_ack stay 0 and count stays 0; after a single write, exactly one read is issued, then empty = 1.
REQ-035 Reset asserted for one cycle mid-burst (count = 7): the next cycle shows count = 0 and all strobes 0; on the first conflict after reset, req0 wins.
REQ-036 fifo_overflow is pulsed high for one cycle: err = 1 and stays 1 until reset; with FIFO_ARB_STATS_EN defined, the gnt_cnt values match the grant totals from the scenario in REQ-031.
